// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the N-channel PWM colour sequencer.
package pwm_seq_pkg;

  localparam int unsigned RES_BITS = 8;

  typedef logic [RES_BITS-1:0] level_t;

  localparam level_t PWM_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_FADE  = 2'd2
  } state_t;

  // Move a level one LSB toward its target; width-agnostic so any resolution can use it.
  function automatic int unsigned step_toward(input int unsigned level, input int unsigned target);
    if (level < target) begin
      return level + 1;
    end else if (level > target) begin
      return level - 1;
    end
    return level;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty shadow register reloaded on the period boundary plus the output flop.
module pwm_channel #(
  parameter int unsigned R = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [R-1:0] pwm_cnt,
  input  logic [R-1:0] level,
  output logic         pwm
);

  logic [R-1:0] act;

  // act only changes on the last count of a period, so a duty change never splits a period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act <= '0;
      pwm <= 1'b0;
    end else begin
      if (pwm_cnt == '1) begin
        act <= level;
      end
      pwm <= (pwm_cnt < act);
    end
  end

endmodule

// File: rtl/pwm_color_sequencer.sv
// N-channel PWM engine with a host-written step table and dwell/advance sequencer.
// Optional linear fade between steps is built when PWM_SEQ_FADE_EN is defined.
module pwm_color_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned CHANNELS            = 3,
  parameter int unsigned PWM_RESOLUTION_BITS = RES_BITS,
  parameter int unsigned STEPS               = 8,
  parameter int unsigned DWELL_BITS          = 26,
  parameter int unsigned FADE_BITS           = 16,
  localparam int unsigned R  = PWM_RESOLUTION_BITS,
  localparam int unsigned AW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic [AW-1:0]         last_step,
  input  logic [DWELL_BITS-1:0] dwell_cycles,
  input  logic [FADE_BITS-1:0]  fade_period,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CHANNELS*R-1:0] wr_data,
  output logic [CHANNELS-1:0]   pwm_o,
  output logic [AW-1:0]         step_idx,
  output logic                  step_done,
  output logic                  busy
);

  logic [CHANNELS*R-1:0] table_q [STEPS];

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         last_eff, nxt;
  logic [R-1:0]          cur_q [CHANNELS];
  logic [R-1:0]          cur_d [CHANNELS];
  logic [DWELL_BITS-1:0] dwell_q, dwell_d, dwell_load;
  logic                  step_done_q, step_done_d;
  logic                  busy_q;
  logic                  expire;
  logic [R-1:0]          pwm_cnt;

`ifdef PWM_SEQ_FADE_EN
  logic [FADE_BITS-1:0]  fade_q, fade_d, fade_load;
  logic                  all_eq;

  assign fade_load = (fade_period == '0) ? FADE_BITS'(1) : fade_period;
`else
  logic                  unused_fade_period;

  assign unused_fade_period = ^fade_period;
`endif

  assign last_eff   = (32'(last_step) >= STEPS) ? AW'(STEPS - 1) : last_step;
  assign nxt        = (idx_q >= last_eff) ? '0 : idx_q + AW'(1);
  assign dwell_load = (dwell_cycles == '0) ? DWELL_BITS'(1) : dwell_cycles;
  assign expire     = (state_q == ST_DWELL) && (dwell_q == DWELL_BITS'(1));

  // Step table: out-of-range addresses are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < STEPS; s++) begin
        table_q[s] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < STEPS)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + R'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dwell_q     <= '0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cur_q[c] <= '0;
      end
`ifdef PWM_SEQ_FADE_EN
      fade_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dwell_q     <= dwell_d;
      step_done_q <= step_done_d;
      busy_q      <= (state_d != ST_IDLE);
      cur_q       <= cur_d;
`ifdef PWM_SEQ_FADE_EN
      fade_q      <= fade_d;
`endif
    end
  end

  // Sequencer next state; a dropped run overrides every transition except the step_done pulse
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    dwell_d     = dwell_q;
    step_done_d = 1'b0;
`ifdef PWM_SEQ_FADE_EN
    fade_d      = fade_q;
    all_eq      = 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_DWELL;
          idx_d   = '0;
          dwell_d = dwell_load;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            cur_d[c] = table_q[0][c*R +: R];
          end
        end
      end

      ST_DWELL: begin
        dwell_d = dwell_q - DWELL_BITS'(1);
        if (expire) begin
          step_done_d = 1'b1;
          idx_d       = nxt;
`ifdef PWM_SEQ_FADE_EN
          state_d     = ST_FADE;
          fade_d      = fade_load;
`else
          dwell_d     = dwell_load;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            cur_d[c] = table_q[nxt][c*R +: R];
          end
`endif
        end
      end

`ifdef PWM_SEQ_FADE_EN
      ST_FADE: begin
        if (fade_q <= FADE_BITS'(1)) begin
          fade_d = fade_load;
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            cur_d[c] = R'(step_toward(32'(cur_q[c]), 32'(table_q[idx_q][c*R +: R])));
          end
        end else begin
          fade_d = fade_q - FADE_BITS'(1);
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (cur_d[c] != table_q[idx_q][c*R +: R]) begin
            all_eq = 1'b0;
          end
        end
        if (all_eq) begin
          state_d = ST_DWELL;
          dwell_d = dwell_load;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!run) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cur_d[c] = '0;
      end
`ifdef PWM_SEQ_FADE_EN
      fade_d  = '0;
`endif
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .R(R)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .pwm_cnt (pwm_cnt),
      .level   (cur_q[g]),
      .pwm     (pwm_o[g])
    );
  end

  assign step_idx  = idx_q;
  assign step_done = step_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_color_sequencer.sv
// Directed bench for pwm_color_sequencer (CHANNELS=3, R=8, STEPS=8); fade checks need PWM_SEQ_FADE_EN.
module tb_pwm_color_sequencer;
  import pwm_seq_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [2:0]  last_step;
  logic [25:0] dwell_cycles;
  logic [15:0] fade_period;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [2:0]  pwm_o;
  logic [2:0]  step_idx;
  logic        step_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pwm_color_sequencer #(
    .CHANNELS(3), .PWM_RESOLUTION_BITS(8), .STEPS(8), .DWELL_BITS(26), .FADE_BITS(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .last_step    (last_step),
    .dwell_cycles (dwell_cycles),
    .fade_period  (fade_period),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_o        (pwm_o),
    .step_idx     (step_idx),
    .step_done    (step_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_row(input logic [2:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic measure(output int h0, output int h1, output int h2);
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      h0 += int'(pwm_o[0]);
      h1 += int'(pwm_o[1]);
      h2 += int'(pwm_o[2]);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!step_done && n < limit);
  endtask

  initial begin
    int h0, h1, h2, n;
    reset_n = 1'b0; run = 1'b0; last_step = 3'd0; dwell_cycles = 26'd100000;
    fade_period = 16'd1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 24'd0;
    repeat (3) tick();
    check("rst_pwm", 32'(pwm_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(step_idx), 32'd0);
    check("rst_done", 32'(step_done), 32'd0);
    reset_n = 1'b1;
    tick();

    // duty levels on a held step
    write_row(3'd0, {8'd0, 8'd128, 8'd255});
    run = 1'b1;
    repeat (600) tick();
    check("run_busy", 32'(busy), 32'd1);
    measure(h0, h1, h2);
    check("duty_255", 32'(h0), 32'd255);
    check("duty_128", 32'(h1), 32'd128);
    check("duty_0", 32'(h2), 32'd0);

    // sequencing through three steps
    run = 1'b0;
    repeat (2) tick();
    check("stop_busy", 32'(busy), 32'd0);
    write_row(3'd1, {8'd70, 8'd60, 8'd50});
    write_row(3'd2, {8'd3, 8'd2, 8'd1});
    last_step = 3'd2; dwell_cycles = 26'd1000;
    run = 1'b1;
    tick();
    wait_done(3000, n);
    check("seq_gap1", 32'(n), 32'd1000);
    check("seq_idx1", 32'(step_idx), 32'd1);
    wait_done(3000, n);
    check("seq_gap2", 32'(n), 32'd1000);
    check("seq_idx2", 32'(step_idx), 32'd2);
    tick();
    check("done_pulse", 32'(step_done), 32'd0);
    wait_done(3000, n);
    check("seq_gap3", 32'(n), 32'd999);
    check("seq_wrap", 32'(step_idx), 32'd0);
    wait_done(3000, n);
    check("seq_gap4", 32'(n), 32'd1000);
    check("seq_idx1b", 32'(step_idx), 32'd1);

`ifndef PWM_SEQ_FADE_EN
    // stop on the expiry cycle: done still pulses, FSM idles
    repeat (999) tick();
    run = 1'b0;
    tick();
    check("stop_done", 32'(step_done), 32'd1);
    check("stop_idle", 32'(busy), 32'd0);
    repeat (300) tick();
    check("stop_pwm", 32'(pwm_o), 32'd0);

    // dwell of 0 behaves as 1
    dwell_cycles = 26'd0; last_step = 3'd1;
    run = 1'b1;
    tick();
    tick();
    check("dw0_done1", 32'(step_done), 32'd1);
    check("dw0_idx1", 32'(step_idx), 32'd1);
    tick();
    check("dw0_done2", 32'(step_done), 32'd1);
    check("dw0_idx0", 32'(step_idx), 32'd0);
    run = 1'b0;
    repeat (2) tick();

    // live write lands at the next fetch
    dwell_cycles = 26'd2000;
    run = 1'b1;
    tick();
    repeat (10) tick();
    write_row(3'd1, {8'd30, 8'd20, 8'd10});
    wait_done(5000, n);
    check("live_idx", 32'(step_idx), 32'd1);
    repeat (300) tick();
    measure(h0, h1, h2);
    check("live_d0", 32'(h0), 32'd10);
    check("live_d1", 32'(h1), 32'd20);
    check("live_d2", 32'(h2), 32'd30);
`else
    // fade 0 -> {10,3,0} at 4 cycles per LSB
    run = 1'b0;
    repeat (2) tick();
    write_row(3'd0, 24'd0);
    write_row(3'd1, {8'd0, 8'd3, 8'd10});
    last_step = 3'd1; dwell_cycles = 26'd100; fade_period = 16'd4;
    run = 1'b1;
    tick();
    wait_done(500, n);
    check("fade_dwell", 32'(n), 32'd100);
    check("fade_state", 32'(dut.state_q), 32'(ST_FADE));
    begin
      logic       mono;
      logic [7:0] prev;
      mono = 1'b1;
      prev = dut.cur_q[0];
      n = 0;
      do begin
        tick();
        n++;
        if (dut.cur_q[0] < prev || dut.cur_q[0] > prev + 8'd1) mono = 1'b0;
        prev = dut.cur_q[0];
      end while (dut.state_q == ST_FADE && n < 200);
      check("fade_mono", 32'(mono), 32'd1);
    end
    check("fade_len", 32'(n), 32'd40);
    check("fade_ch0", 32'(dut.cur_q[0]), 32'd10);
    check("fade_ch1", 32'(dut.cur_q[1]), 32'd3);
    check("fade_dw", 32'(dut.state_q), 32'(ST_DWELL));
    wait_done(500, n);
    repeat (5) tick();
    check("fade_back", 32'(dut.state_q), 32'(ST_FADE));
`endif

    // asynchronous reset mid-run
    reset_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_o), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_idx", 32'(step_idx), 32'd0);
    check("arst_tbl", 32'(dut.table_q[1]), 32'd0);
    reset_n = 1'b1;
    run = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
